ecc_scrubber: RTL and testbench
===============================

# ecc_scrubber

Background memory scrubber for Hamming-ECC protected RAM. It walks the address space, reads each code word, and inspects the flags of an external `ecc_dec` instance. Single-bit errors are written back in corrected form through an external `ecc_enc`. Double-bit errors and corrections are counted and reported. It sits beside the ECC datapath as a low-priority master on the memory port; a system arbiter grants it access.

## Interface
Parameters:
- `K`, 64, information bits per word (matches `ecc_enc`/`ecc_dec`)
- `AW`, 10, address width; scrub range is 0 .. `2**AW-1`
- `DEC_LATENCY`, 0, cycles from `mem_rvalid_i` to valid `dec_*` inputs (equals `ecc_dec` `LATENCY`)
- `CW`, 16, counter width for interval and error counters

Ports (clock and reset first):
- `clk_i`  in  1  clock; all logic on rising edge
- `rst_ni`  in  1  reset; one clock; reset is synchronous and active-low
- `en_i`  in  1  continuous mode: restart a pass automatically after `done_o`
- `start_i`  in  1  pulse: begin one pass (ignored while `busy_o`)
- `interval_i`  in  CW  idle cycles inserted between word accesses
- `mem_req_o`  out  1  memory request; held until granted
- `mem_we_o`  out  1  1 = write-back, 0 = read
- `mem_addr_o`  out  AW  word address
- `mem_gnt_i`  in  1  request accepted this cycle
- `mem_rvalid_i`  in  1  read data valid at decoder input
- `dec_q_i`  in  K  corrected information bits from `ecc_dec`
- `dec_sb_err_i`  in  1  single-bit error flag
- `dec_db_err_i`  in  1  double-bit error flag
- `enc_d_o`  out  K  data to `ecc_enc`; the encoder output drives memory write data
- `busy_o`  out  1  pass in progress
- `done_o`  out  1  one-cycle pulse at end of pass
- `sb_cnt_o`  out  CW  corrected words this pass, saturating
- `db_cnt_o`  out  CW  uncorrectable words this pass, saturating
- `db_addr_o`  out  AW  address of the most recent double-bit error
- `db_irq_o`  out  1  sticky; set on any double-bit error; cleared by `start_i`

## Operation
The FSM has the states IDLE, GAP, READ, RESP, WRITE and NEXT.
- **IDLE:** on `start_i`, or `en_i` one cycle after `done_o`, go to GAP.
  - Address is cleared to 0.
  - `sb_cnt_o` and `db_cnt_o` are cleared.
  - `busy_o` is 1 from the next cycle.
- **GAP:** load the interval counter with `interval_i`, then count down.
  - At 0, go to READ.
  - `interval_i`=0 gives no gap cycles.
- **READ:** assert `mem_req_o` with `mem_we_o`=0 and the current address.
  - On `mem_gnt_i`, drop the request the next cycle and go to RESP.
- **RESP:** wait for `mem_rvalid_i`, then delay `DEC_LATENCY` cycles with a delay counter, then sample the `dec_*` inputs.
  - `dec_db_err_i`=1: increment `db_cnt_o`, load `db_addr_o`, set `db_irq_o`, go to NEXT. No write-back.
  - `dec_sb_err_i`=1 and `dec_db_err_i`=0: register `dec_q_i` into `enc_d_o`, increment `sb_cnt_o`, go to WRITE.
  - Otherwise go to NEXT.
- **WRITE:** assert `mem_req_o` with `mem_we_o`=1, the same address, and `enc_d_o` stable. On `mem_gnt_i`, go to NEXT.
- **NEXT:**
  - If address = `2**AW-1`: pulse `done_o`, go to IDLE, clear `busy_o`. The address wraps to 0.
  - Otherwise: address+1, go to GAP.
- Counters saturate at `2**CW-1` and never wrap.
- `start_i` while busy is ignored.
- Deasserting `en_i` mid-pass finishes the current pass and then stops.
- `mem_rvalid_i` outside RESP is ignored.

## Timing
- Reset values:
  - state IDLE, address 0
  - `mem_req_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `enc_d_o`=0
  - `busy_o`=0, `done_o`=0
  - `sb_cnt_o`=0, `db_cnt_o`=0, `db_addr_o`=0, `db_irq_o`=0
- Reset mid-pass aborts immediately.
  - `mem_req_o` drops in the cycle after the reset edge.
  - A pending read response is discarded.
- All outputs are registered. `mem_req_o` asserts the cycle after entering READ or WRITE.
- `mem_req_o`, `mem_we_o`, `mem_addr_o` and `enc_d_o` hold stable while `mem_gnt_i`=0.
- Minimum cycles per clean word with zero wait states, `interval_i`=0, `DEC_LATENCY`=0: 4 (GAP, READ, RESP, NEXT). A corrected word adds the WRITE handshake.
- `done_o` is high for exactly one cycle. `busy_o` falls in that same cycle.
- Simultaneous `dec_sb_err_i` and `dec_db_err_i`: treated as double-bit error only.

## Test plan
- **Clean memory:** `AW`=4, `interval_i`=0, `start_i` pulse.
  - Expect 16 reads at addresses 0..15 and no writes.
  - `done_o` pulses once; `sb_cnt_o`=0, `db_cnt_o`=0.
- **Single flip:** bit 5 flipped in the word at address 3.
  - Expect exactly one write to address 3, with `enc_d_o` equal to the original data.
  - `sb_cnt_o`=1. A second pass reports `sb_cnt_o`=0.
- **Double flip:** bits 2 and 9 flipped at address 7.
  - Expect no write, `db_cnt_o`=1, `db_addr_o`=7, `db_irq_o`=1.
  - `db_irq_o` stays 1 after `done_o` and clears on the next `start_i`.
- **Backpressure and latency:** `mem_gnt_i` withheld 5 cycles per request, `DEC_LATENCY`=2, `interval_i`=3.
  - Request signals stay stable while withheld.
  - Flags are sampled exactly 2 cycles after `mem_rvalid_i`.
  - Gaps are exactly 3 cycles.
- **Continuous mode and reset:** `en_i`=1.
  - A new pass starts the cycle after `done_o`.
  - `rst_ni`=0 during WRITE: all outputs at reset values next cycle; no write is issued after reset.
- **Saturation:** `CW`=2, every word single-bit corrupted, `AW`=3.
  - `sb_cnt_o` stops at 3; all 8 words are written back.

Source files
------------

// File: rtl/ecc_scrubber.sv
// Background ECC scrubber: walks every word address, reads it through the
// external decoder, writes single-bit errors back in corrected form and
// counts/report corrected and uncorrectable words for each pass.
module ecc_scrubber #(
   parameter int K           = 64,
   parameter int AW          = 10,
   parameter int DEC_LATENCY = 0,
   parameter int CW          = 16
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          en_i,
   input  logic          start_i,
   input  logic [CW-1:0] interval_i,
   output logic          mem_req_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   input  logic          mem_gnt_i,
   input  logic          mem_rvalid_i,
   input  logic [K-1:0]  dec_q_i,
   input  logic          dec_sb_err_i,
   input  logic          dec_db_err_i,
   output logic [K-1:0]  enc_d_o,
   output logic          busy_o,
   output logic          done_o,
   output logic [CW-1:0] sb_cnt_o,
   output logic [CW-1:0] db_cnt_o,
   output logic [AW-1:0] db_addr_o,
   output logic          db_irq_o
);

   // Delay counter holds the remaining decoder latency after the cycle that
   // saw mem_rvalid_i, so it only needs to reach DEC_LATENCY-1.
   localparam int DW = (DEC_LATENCY > 1) ? $clog2(DEC_LATENCY) : 1;
   localparam logic [DW-1:0] DLY_INIT = DW'((DEC_LATENCY > 0) ? DEC_LATENCY - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GAP,
      S_READ,
      S_RESP,
      S_WRITE,
      S_NEXT
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [CW-1:0] gap_q, gap_d;
   logic [DW-1:0] dly_q, dly_d;
   logic          got_q, got_d;
   logic          req_q, req_d;
   logic          we_q, we_d;
   logic [K-1:0]  enc_q, enc_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [CW-1:0] sb_cnt_q, sb_cnt_d;
   logic [CW-1:0] db_cnt_q, db_cnt_d;
   logic [AW-1:0] db_addr_q, db_addr_d;
   logic          irq_q, irq_d;
   logic          sample;

   // Error counters stick at all-ones instead of wrapping.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (&v) ? v : v + CW'(1);
   endfunction

   // Next-state and next-output logic for the scrub walk.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      gap_d     = gap_q;
      dly_d     = dly_q;
      got_d     = got_q;
      req_d     = req_q;
      we_d      = we_q;
      enc_d     = enc_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      sb_cnt_d  = sb_cnt_q;
      db_cnt_d  = db_cnt_q;
      db_addr_d = db_addr_q;
      irq_d     = irq_q;
      sample    = 1'b0;

      case (state_q)
         S_IDLE: begin
            // done_q is only high in the first IDLE cycle, which gives the
            // automatic restart in continuous mode.
            if (start_i || (en_i && done_q)) begin
               state_d  = S_GAP;
               addr_d   = '0;
               sb_cnt_d = '0;
               db_cnt_d = '0;
               busy_d   = 1'b1;
               gap_d    = interval_i;
               if (start_i) begin
                  irq_d = 1'b0;
               end
            end
         end
         S_GAP: begin
            if (gap_q == '0) begin
               state_d = S_READ;
               req_d   = 1'b1;
               we_d    = 1'b0;
            end else begin
               gap_d = gap_q - CW'(1);
            end
         end
         S_READ: begin
            if (mem_gnt_i) begin
               req_d   = 1'b0;
               got_d   = 1'b0;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (!got_q) begin
               if (mem_rvalid_i) begin
                  if (DEC_LATENCY == 0) begin
                     sample = 1'b1;
                  end else begin
                     got_d = 1'b1;
                     dly_d = DLY_INIT;
                  end
               end
            end else if (dly_q == '0) begin
               sample = 1'b1;
            end else begin
               dly_d = dly_q - DW'(1);
            end

            // A double-bit flag wins over a simultaneous single-bit flag.
            if (sample) begin
               got_d = 1'b0;
               if (dec_db_err_i) begin
                  db_cnt_d  = sat_inc(db_cnt_q);
                  db_addr_d = addr_q;
                  irq_d     = 1'b1;
                  state_d   = S_NEXT;
               end else if (dec_sb_err_i) begin
                  enc_d    = dec_q_i;
                  sb_cnt_d = sat_inc(sb_cnt_q);
                  req_d    = 1'b1;
                  we_d     = 1'b1;
                  state_d  = S_WRITE;
               end else begin
                  state_d = S_NEXT;
               end
            end
         end
         S_WRITE: begin
            if (mem_gnt_i) begin
               req_d   = 1'b0;
               we_d    = 1'b0;
               state_d = S_NEXT;
            end
         end
         S_NEXT: begin
            if (&addr_q) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               addr_d  = '0;
               state_d = S_IDLE;
            end else begin
               addr_d  = addr_q + AW'(1);
               gap_d   = interval_i;
               state_d = S_GAP;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any pass in flight.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         gap_q     <= '0;
         dly_q     <= '0;
         got_q     <= 1'b0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         enc_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         sb_cnt_q  <= '0;
         db_cnt_q  <= '0;
         db_addr_q <= '0;
         irq_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         gap_q     <= gap_d;
         dly_q     <= dly_d;
         got_q     <= got_d;
         req_q     <= req_d;
         we_q      <= we_d;
         enc_q     <= enc_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         sb_cnt_q  <= sb_cnt_d;
         db_cnt_q  <= db_cnt_d;
         db_addr_q <= db_addr_d;
         irq_q     <= irq_d;
      end
   end

   assign mem_req_o  = req_q;
   assign mem_we_o   = we_q;
   assign mem_addr_o = addr_q;
   assign enc_d_o    = enc_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign sb_cnt_o   = sb_cnt_q;
   assign db_cnt_o   = db_cnt_q;
   assign db_addr_o  = db_addr_q;
   assign db_irq_o   = irq_q;

endmodule

// File: tb/tb_ecc_scrubber.sv
// Scoreboard bench for ecc_scrubber: a memory/decoder model answers the DUT,
// the stimulus queues expected bus transactions and end-of-pass results, and
// a monitor compares them as the DUT produces them.
module tb_ecc_scrubber;

   localparam int K  = 64;
   localparam int AW = 3;
   localparam int L  = 2;
   localparam int CW = 2;
   localparam int NW = 8;

   logic          clk;
   logic          rst_ni;
   logic          en_i;
   logic          start_i;
   logic [CW-1:0] interval_i;
   logic          mem_req_o;
   logic          mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic          mem_gnt_i = 1'b0;
   logic          mem_rvalid_i = 1'b0;
   logic [K-1:0]  dec_q_i = '0;
   logic          dec_sb_err_i = 1'b0;
   logic          dec_db_err_i = 1'b0;
   logic [K-1:0]  enc_d_o;
   logic          busy_o;
   logic          done_o;
   logic [CW-1:0] sb_cnt_o;
   logic [CW-1:0] db_cnt_o;
   logic [AW-1:0] db_addr_o;
   logic          db_irq_o;

   ecc_scrubber #(.K(K), .AW(AW), .DEC_LATENCY(L), .CW(CW)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .en_i(en_i), .start_i(start_i),
      .interval_i(interval_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
      .dec_q_i(dec_q_i), .dec_sb_err_i(dec_sb_err_i), .dec_db_err_i(dec_db_err_i),
      .enc_d_o(enc_d_o), .busy_o(busy_o), .done_o(done_o), .sb_cnt_o(sb_cnt_o),
      .db_cnt_o(db_cnt_o), .db_addr_o(db_addr_o), .db_irq_o(db_irq_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [K-1:0]  d;
      int            delta;
   } txn_t;

   typedef struct {
      logic [CW-1:0] sb;
      logic [CW-1:0] db;
      logic [AW-1:0] dba;
      logic          irq;
      logic          busy_after;
   } done_t;

   txn_t         exp_q[$];
   done_t        done_exp_q[$];
   logic [K-1:0] mem_data[NW];
   logic [K-1:0] mem_flip[NW];
   int           gw;
   int           ival;
   int           cyc = 0;
   int           n_chk = 0;
   int           n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Memory + decoder model: grant after gw withheld cycles, rvalid one cycle
   // after a read grant, decoder flags valid only L cycles after rvalid.
   initial begin
      int wcnt;
      int rv_at;
      int dec_at;
      logic [AW-1:0] rd_addr;
      int pc;
      wcnt = 0; rv_at = -1; dec_at = -1; rd_addr = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_ni) begin
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
            dec_sb_err_i = 1'b0; dec_db_err_i = 1'b0; dec_q_i = '0;
            wcnt = 0; rv_at = -1; dec_at = -1;
         end else begin
            mem_rvalid_i = (cyc == rv_at);
            if (cyc == dec_at) begin
               pc = $countones(mem_flip[rd_addr]);
               dec_sb_err_i = (pc == 1) || (pc == 3);
               dec_db_err_i = (pc >= 2);
               dec_q_i = (pc == 1) ? mem_data[rd_addr] : (mem_data[rd_addr] ^ mem_flip[rd_addr]);
            end else begin
               dec_sb_err_i = 1'b0; dec_db_err_i = 1'b0; dec_q_i = '0;
            end
            if (mem_req_o) begin
               if (wcnt >= gw) begin
                  mem_gnt_i = 1'b1; wcnt = 0;
               end else begin
                  mem_gnt_i = 1'b0; wcnt++;
               end
            end else begin
               mem_gnt_i = 1'b0; wcnt = 0;
            end
            if (mem_req_o && mem_gnt_i) begin
               if (!mem_we_o) begin
                  rd_addr = mem_addr_o; rv_at = cyc + 1; dec_at = cyc + 1 + L;
               end else begin
                  mem_data[mem_addr_o] = enc_d_o; mem_flip[mem_addr_o] = '0;
               end
            end
         end
      end
   end

   // Monitor: checks each bus handshake, request stability under backpressure
   // and every done pulse against the queued expectations.
   initial begin
      logic          arm;
      logic          h_we;
      logic [AW-1:0] h_addr;
      logic [K-1:0]  h_d;
      logic          chk_after;
      done_t         pend;
      txn_t          t;
      done_t         de;
      int            last_hs;
      arm = 1'b0; chk_after = 1'b0; last_hs = 0;
      h_we = 1'b0; h_addr = '0; h_d = '0;
      pend = '{sb: '0, db: '0, dba: '0, irq: 1'b0, busy_after: 1'b0};
      forever begin
         @(negedge clk);
         #1;
         if (arm) begin
            arm = 1'b0;
            if (rst_ni) begin
               chk("hold_req", {63'd0, mem_req_o}, 64'd1);
               chk("hold_we", {63'd0, mem_we_o}, {63'd0, h_we});
               chk("hold_addr", 64'(mem_addr_o), 64'(h_addr));
               chk("hold_data", enc_d_o, h_d);
            end
         end
         if (chk_after) begin
            chk_after = 1'b0;
            chk("done_one_cycle", {63'd0, done_o}, 64'd0);
            chk("busy_after_done", {63'd0, busy_o}, {63'd0, pend.busy_after});
         end
         if (rst_ni && mem_req_o && !mem_gnt_i) begin
            arm = 1'b1; h_we = mem_we_o; h_addr = mem_addr_o; h_d = enc_d_o;
         end
         if (rst_ni && mem_req_o && mem_gnt_i) begin
            n_chk++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL txn_unexpected: actual we=%0d addr=%0d required no transaction", mem_we_o, mem_addr_o);
            end else begin
               t = exp_q.pop_front();
               chk("txn_we", {63'd0, mem_we_o}, {63'd0, t.we});
               chk("txn_addr", 64'(mem_addr_o), 64'(t.addr));
               if (t.we) chk("txn_wdata", enc_d_o, t.d);
               if (t.delta >= 0) chk("txn_spacing", 64'(cyc - last_hs), 64'(t.delta));
            end
            last_hs = cyc;
         end
         if (rst_ni && done_o) begin
            n_chk++;
            if (done_exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL done_unexpected: actual done_o=1 required 0");
            end else begin
               de = done_exp_q.pop_front();
               chk("sb_cnt", 64'(sb_cnt_o), 64'(de.sb));
               chk("db_cnt", 64'(db_cnt_o), 64'(de.db));
               chk("db_addr", 64'(db_addr_o), 64'(de.dba));
               chk("db_irq", {63'd0, db_irq_o}, {63'd0, de.irq});
               chk("busy_at_done", {63'd0, busy_o}, 64'd0);
               pend = de;
               chk_after = 1'b1;
            end
         end
      end
   end

   task automatic set_mem();
      for (int a = 0; a < NW; a++) begin
         mem_data[a] = 64'h0123_4567_89AB_CDEF + 64'(a) * 64'h0101_0101_0101_0101;
         mem_flip[a] = '0;
      end
   endtask

   // Queue the transactions one pass should produce, with handshake spacing
   // derived from gap, grant wait and decoder latency.
   task automatic build_pass(input logic [CW-1:0] sb, input logic [CW-1:0] db,
                             input logic [AW-1:0] dba, input logic irq, input logic busy_after);
      int prev;
      txn_t t;
      done_t d;
      prev = 0;
      for (int a = 0; a < NW; a++) begin
         t.we = 1'b0; t.addr = AW'(a); t.d = '0;
         t.delta = (prev == 0) ? -1 : (prev == 1) ? (L + ival + gw + 4) : (ival + gw + 3);
         exp_q.push_back(t);
         if ($countones(mem_flip[a]) == 1) begin
            t.we = 1'b1; t.d = mem_data[a]; t.delta = L + gw + 2;
            exp_q.push_back(t);
            prev = 2;
         end else begin
            prev = 1;
         end
      end
      d.sb = sb; d.db = db; d.dba = dba; d.irq = irq; d.busy_after = busy_after;
      done_exp_q.push_back(d);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      #1;
      chk("busy_after_start", {63'd0, busy_o}, 64'd1);
      chk("irq_clear_on_start", {63'd0, db_irq_o}, 64'd0);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (done_o !== 1'b1 && n < 4000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 4000) chk("done_timeout", 64'd0, 64'd1);
      @(negedge clk);
      #2;
      chk("pass_txns_left", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_req"}, {63'd0, mem_req_o}, 64'd0);
      chk({tag, "_we"}, {63'd0, mem_we_o}, 64'd0);
      chk({tag, "_addr"}, 64'(mem_addr_o), 64'd0);
      chk({tag, "_enc"}, enc_d_o, 64'd0);
      chk({tag, "_busy"}, {63'd0, busy_o}, 64'd0);
      chk({tag, "_done"}, {63'd0, done_o}, 64'd0);
      chk({tag, "_sb"}, 64'(sb_cnt_o), 64'd0);
      chk({tag, "_db"}, 64'(db_cnt_o), 64'd0);
      chk({tag, "_dba"}, 64'(db_addr_o), 64'd0);
      chk({tag, "_irq"}, {63'd0, db_irq_o}, 64'd0);
   endtask

   initial begin
      int n;
      rst_ni = 1'b0; en_i = 1'b0; start_i = 1'b0; interval_i = '0;
      gw = 0; ival = 0;
      set_mem();
      repeat (3) @(negedge clk);
      #1;
      check_reset_values("rst");
      rst_ni = 1'b1;

      // Clean memory: eight reads, no writes, zero counts.
      build_pass(2'd0, 2'd0, 3'd0, 1'b0, 1'b0);
      pulse_start();
      wait_done();

      // Single flip at address 3, then a second pass finds it repaired.
      mem_flip[3] = 64'h20;
      build_pass(2'd1, 2'd0, 3'd0, 1'b0, 1'b0);
      pulse_start();
      wait_done();
      build_pass(2'd0, 2'd0, 3'd0, 1'b0, 1'b0);
      pulse_start();
      wait_done();

      // Double flip at address 7: no write, sticky interrupt until next start.
      set_mem();
      mem_flip[7] = 64'h204;
      build_pass(2'd0, 2'd1, 3'd7, 1'b1, 1'b0);
      pulse_start();
      wait_done();
      repeat (3) @(negedge clk);
      #1;
      chk("irq_sticky", {63'd0, db_irq_o}, 64'd1);
      build_pass(2'd0, 2'd1, 3'd7, 1'b1, 1'b0);
      pulse_start();
      wait_done();

      // Backpressure, decoder latency and gaps; a start mid-pass is ignored.
      set_mem();
      gw = 5; ival = 3; interval_i = 2'd3;
      mem_flip[2] = 64'h1 << 40;
      build_pass(2'd1, 2'd0, 3'd7, 1'b0, 1'b0);
      pulse_start();
      repeat (40) @(negedge clk);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      wait_done();

      // Every word single-bit corrupted: count saturates, all words repaired.
      set_mem();
      gw = 0; ival = 0; interval_i = 2'd0;
      for (int a = 0; a < NW; a++) mem_flip[a] = 64'h1 << (a * 3);
      build_pass(2'd3, 2'd0, 3'd7, 1'b0, 1'b0);
      pulse_start();
      wait_done();

      // Every word uncorrectable; low words also raise the single-bit flag.
      set_mem();
      for (int a = 0; a < NW; a++) mem_flip[a] = (a < 4) ? 64'h7000 : 64'h0300;
      build_pass(2'd0, 2'd3, 3'd7, 1'b1, 1'b0);
      pulse_start();
      wait_done();

      // Continuous mode, dropped mid-pass: the pass finishes and stops.
      set_mem();
      en_i = 1'b1;
      build_pass(2'd0, 2'd0, 3'd7, 1'b0, 1'b0);
      pulse_start();
      repeat (20) @(negedge clk);
      en_i = 1'b0;
      wait_done();
      repeat (5) @(negedge clk);
      #1;
      chk("stopped_after_en_drop", {63'd0, busy_o}, 64'd0);

      // Continuous mode restart, then reset while a write-back is pending.
      set_mem();
      gw = 5;
      en_i = 1'b1;
      build_pass(2'd0, 2'd0, 3'd7, 1'b0, 1'b1);
      pulse_start();
      wait_done();
      mem_flip[6] = 64'h100;
      build_pass(2'd1, 2'd0, 3'd7, 1'b0, 1'b1);
      n = 0;
      while (!(mem_req_o === 1'b1 && mem_we_o === 1'b1) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("write_seen_before_reset", {63'd0, mem_we_o}, 64'd1);
      rst_ni = 1'b0;
      @(negedge clk);
      #1;
      check_reset_values("midrst");
      rst_ni = 1'b1;
      exp_q.delete();
      done_exp_q.delete();
      n = 0;
      repeat (30) begin
         @(negedge clk);
         if (mem_req_o) n++;
      end
      chk("no_req_after_reset", 64'(n), 64'd0);
      chk("idle_after_reset", {63'd0, busy_o}, 64'd0);

      // Recovery: a normal pass after the aborted one.
      en_i = 1'b0;
      gw = 0;
      set_mem();
      build_pass(2'd0, 2'd0, 3'd0, 1'b0, 1'b0);
      pulse_start();
      wait_done();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
